// File: rtl/fir_ax_pkg.sv
// Shared defaults for the shift-coefficient FIR and its approximate Sklansky
// adder chain: parameter defaults, the tap shift-field type and the reset
// shift pattern (tap i defaults to a right shift of TAPS-i).
package fir_ax_pkg;

   localparam int W_DEF    = 16;
   localparam int TAPS_DEF = 5;
   localparam int K_DEF    = 4;
   localparam int SHW_DEF  = 5;

   typedef logic [SHW_DEF-1:0] shift_t;

   // Reset value of a tap's right-shift amount.
   function automatic int unsigned default_shift(input int unsigned taps,
                                                 input int unsigned idx);
      return taps - idx;
   endfunction

endpackage

// File: rtl/ax_sklansky_add.sv
// Approximate W-bit adder, purely combinational, carry-out discarded.
// The low K bits use a one-bit-lookback carry.  The carry into bit K is
// a[K-1]&b[K-1], and bits K..W-1 are an exact Sklansky prefix adder.
// Build option: FIR_EXACT_ADD_EN turns the whole adder into an exact modular
// add. The prefix network is then used over all W bits and K has no effect.
module ax_sklansky_add
   import fir_ax_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int K = K_DEF
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] s
);

`ifdef FIR_EXACT_ADD_EN
   // K stays referenced so both builds elaborate from the same parameter set.
   localparam int KE = K * 0;
`else
   localparam int KE = K;
`endif
   localparam int N  = W - KE;
   localparam int LV = (N > 1) ? $clog2(N) : 0;

   logic          cin;
   logic [N-1:0]  ah;
   logic [N-1:0]  bh;
   logic [N-1:0]  sh;

   generate
      if (KE > 0) begin : g_approx
         logic [KE-1:0] sl;
         // Low bits: each bit sees only the generate of the bit directly below.
         always_comb begin
            sl    = '0;
            sl[0] = a[0] ^ b[0];
            for (int j = 1; j < KE; j++)
               sl[j] = a[j] ^ b[j] ^ (a[j-1] & b[j-1]);
         end
         assign cin          = a[KE-1] & b[KE-1];
         assign s[KE-1:0]    = sl;
      end else begin : g_exact
         assign cin = 1'b0;
      end
   endgenerate

   assign ah = a[W-1:KE];
   assign bh = b[W-1:KE];

   // Exact upper section: Sklansky prefix tree.  The carry-in is folded into
   // the generate of the lowest bit so the tree needs no extra input.
   always_comb begin
      logic [N-1:0] gl [0:LV];
      logic [N-1:0] pl [0:LV];
      int           jj;
      gl[0]    = ah & bh;
      pl[0]    = ah ^ bh;
      gl[0][0] = gl[0][0] | (pl[0][0] & cin);
      for (int l = 0; l < LV; l++) begin
         gl[l+1] = gl[l];
         pl[l+1] = pl[l];
         for (int i = 0; i < N; i++) begin
            if (((i >> l) & 1) == 1) begin
               jj          = ((i >> l) << l) - 1;
               gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][jj]);
               pl[l+1][i] = pl[l][i] & pl[l][jj];
            end
         end
      end
      sh    = '0;
      sh[0] = pl[0][0] ^ cin;
      for (int i = 1; i < N; i++)
         sh[i] = pl[0][i] ^ gl[LV][i-1];
   end

   assign s[W-1:KE] = sh;

endmodule

// File: rtl/fir_axsk_pipe.sv
// Direct-form FIR with power-of-two (right-shift) coefficients.  Tap terms
// are summed in fixed order through a chain of approximate Sklansky adders.
// The bench supplies a valid-qualified sample stream.  Tap shifts are
// programmable at run time.  out_valid is suppressed until the delay line
// holds TAPS-1 real samples, and the output is registered.
// Build option: FIR_EXACT_ADD_EN (see ax_sklansky_add) selects exact adders.
module fir_axsk_pipe
   import fir_ax_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int TAPS = TAPS_DEF,
   parameter int K    = K_DEF,
   parameter int SHW  = SHW_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [W-1:0]             x,
   input  logic                     cfg_we,
   input  logic [$clog2(TAPS)-1:0]  cfg_idx,
   input  logic [SHW-1:0]           cfg_shift,
   output logic                     out_valid,
   output logic [W-1:0]             y,
   output logic                     primed
);

   localparam int              IW   = $clog2(TAPS);
   localparam logic [IW-1:0]   LAST = IW'(TAPS - 1);

   logic [W-1:0]               d_reg   [1:TAPS-1];
   logic [SHW-1:0]             shift_r [0:TAPS-1];
   logic [IW-1:0]              count;
   logic [TAPS-1:0][W-1:0]     m;
   logic [TAPS-1:0][W-1:0]     acc;

   // Tap terms: d[0] is the live input sample, shifts of W or more give 0.
   generate
      for (genvar i = 0; i < TAPS; i++) begin : g_tap
         logic [W-1:0] di;
         if (i == 0) begin : g_live
            assign di = x;
         end else begin : g_reg
            assign di = d_reg[i];
         end
         assign m[i] = (int'(shift_r[i]) >= W) ? '0 : (di >> shift_r[i]);
      end
   endgenerate

   // Fixed accumulation order: acc_i = axadd(acc_{i-1}, m[i]).
   assign acc[0] = m[0];
   generate
      for (genvar i = 1; i < TAPS; i++) begin : g_add
         ax_sklansky_add #(.W(W), .K(K)) u_add (
            .a (acc[i-1]),
            .b (m[i]),
            .s (acc[i])
         );
      end
   endgenerate

   // Shift register file.  An in-flight sample still sees the old shift
   // because the write only lands at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TAPS; i++)
            shift_r[i] <= SHW'(default_shift(TAPS, i));
      end else if (cfg_we && (int'(cfg_idx) < TAPS)) begin
         shift_r[cfg_idx] <= cfg_shift;
      end
   end

   // Delay line advances only on accepted samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < TAPS; i++)
            d_reg[i] <= '0;
      end else if (in_valid) begin
         d_reg[1] <= x;
         for (int i = 2; i < TAPS; i++)
            d_reg[i] <= d_reg[i-1];
      end
   end

   // Warm-up counter, output register and output-valid strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= '0;
         out_valid <= 1'b0;
         y         <= '0;
      end else begin
         out_valid <= in_valid && (count == LAST);
         if (in_valid) begin
            y <= acc[TAPS-1];
            if (count != LAST)
               count <= count + 1'b1;
         end
      end
   end

   assign primed = (count == LAST);

endmodule

// File: tb/tb_fir_axsk_pipe.sv
// Directed bench for fir_axsk_pipe (default parameters).  Stimulus pushes
// hand-computed outputs into a queue.  A negedge monitor pops the queue on
// every out_valid, and any out_valid with nothing queued is flagged.
module tb_fir_axsk_pipe;

`ifdef FIR_EXACT_ADD_EN
   localparam bit EXACT = 1'b1;
`else
   localparam bit EXACT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] x;
   logic        cfg_we;
   logic [2:0]  cfg_idx;
   logic [4:0]  cfg_shift;
   logic        out_valid;
   logic [15:0] y;
   logic        primed;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_q [$];
   string       cur_test = "reset";

   logic [15:0] imp_x [10] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h8000,
                               16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
   logic [15:0] imp_y [10] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0400,
                               16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h0};

   fir_axsk_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .x         (x),
      .cfg_we    (cfg_we),
      .cfg_idx   (cfg_idx),
      .cfg_shift (cfg_shift),
      .out_valid (out_valid),
      .y         (y),
      .primed    (primed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid !== 1'b0) begin
         if (exp_q.size() == 0)
            chk({cur_test, " unexpected out_valid"}, {31'b0, out_valid}, 32'd0);
         else
            chk({cur_test, " y"}, {16'b0, y}, {16'b0, exp_q.pop_front()});
      end
   end

   task automatic step(input logic v, input logic [15:0] xv);
      in_valid = v;
      x        = xv;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic feed(input logic [15:0] xv, input logic [15:0] ey);
      exp_q.push_back(ey);
      step(1'b1, xv);
   endtask

   task automatic drain();
      step(1'b0, 16'h0);
      #1;
      chk({cur_test, " pending outputs"}, exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic write_shift(input logic [2:0] idx, input logic [4:0] sh);
      cfg_we    = 1'b1;
      cfg_idx   = idx;
      cfg_shift = sh;
      step(1'b0, 16'h0);
      cfg_we    = 1'b0;
   endtask

   // Impulse through default shifts; gapped inserts an idle cycle with junk x
   // after every sample and checks that y holds and out_valid stays low.
   task automatic run_impulse(input bit gapped);
      for (int i = 0; i < 10; i++) begin
         if (i >= 4) feed(imp_x[i], imp_y[i]);
         else        step(1'b1, imp_x[i]);
         if (i == 2) chk({cur_test, " primed early"}, {31'b0, primed}, 32'd0);
         if (i == 3) chk({cur_test, " primed"}, {31'b0, primed}, 32'd1);
         if (gapped) begin
            step(1'b0, 16'hDEAD);
            chk({cur_test, " gap out_valid"}, {31'b0, out_valid}, 32'd0);
            chk({cur_test, " gap y hold"}, {16'b0, y}, {16'b0, imp_y[i]});
         end
      end
      drain();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; x = '0;
      cfg_we = 1'b0; cfg_idx = '0; cfg_shift = '0;
      repeat (3) @(negedge clk);
      chk("reset out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset y", {16'b0, y}, 32'd0);
      chk("reset primed", {31'b0, primed}, 32'd0);
      rst = 1'b0;

      cur_test = "impulse";
      run_impulse(1'b0);

      cur_test = "gapped";
      do_reset();
      run_impulse(1'b1);

      cur_test = "cfg out of range";
      do_reset();
      write_shift(3'd7, 5'd0);
      run_impulse(1'b0);

      cur_test = "cfg collision";
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 16'h0);
      cfg_we = 1'b1; cfg_idx = 3'd0; cfg_shift = 5'd0;
      feed(16'h0100, 16'h0008);
      cfg_we = 1'b0;
      feed(16'h0100, 16'h0110);
      drain();

      cur_test = "approx";
      do_reset();
      write_shift(3'd0, 5'd0);
      write_shift(3'd1, 5'd0);
      write_shift(3'd2, 5'd16);
      write_shift(3'd3, 5'd16);
      write_shift(3'd4, 5'd16);
      for (int i = 0; i < 4; i++) step(1'b1, 16'h0);
      feed(16'h0001, 16'h0001);
      feed(16'h000F, EXACT ? 16'h0010 : 16'h000C);
      feed(16'h0033, EXACT ? 16'h0042 : 16'h003A);
      feed(16'hFFF0, 16'h0023);
      feed(16'h0FF8, 16'h0FE8);
      feed(16'h0008, 16'h1000);
      drain();

      cur_test = "reset mid-stream";
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 16'h0);
      feed(16'h8000, 16'h0400);
      feed(16'h0000, 16'h0800);
      #1;
      chk("mid primed before rst", {31'b0, primed}, 32'd1);
      exp_q.delete();
      rst = 1'b1;
      step(1'b1, 16'h0);
      rst = 1'b0;
      chk("mid rst out_valid", {31'b0, out_valid}, 32'd0);
      chk("mid rst y", {16'b0, y}, 32'd0);
      chk("mid rst primed", {31'b0, primed}, 32'd0);
      step(1'b1, 16'h8000);
      for (int i = 0; i < 3; i++) step(1'b1, 16'h0);
      chk("mid re-primed", {31'b0, primed}, 32'd1);
      feed(16'h0000, 16'h4000);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
